// File: rtl/hilo_control_sequencer_if.sv
// Control bundle between the HI/LO sequencer and the System datapath.
// master = sequencer side, slave = datapath/memory side.
interface hilo_control_sequencer_if #(
    parameter int OPCODE_WIDTH = 5,
    parameter int COUNT_WIDTH  = 16
);
    logic                    i_run;
    logic [OPCODE_WIDTH-1:0] i_ir_opcode;
    logic                    i_memory_done;

    logic o_PCout, o_IncPC, o_MARin, o_Zin;
    logic o_Zlo_out, o_PCin, o_MDRin, o_Mem_Read;
    logic o_Mem_enable512x32, o_MDRout, o_IRin;
    logic o_Gra, o_Grb, o_Rout, o_BAout, o_Yin;
    logic o_Cout, o_HIout, o_LOout, o_HIin, o_LOin, o_Rin;

    logic [OPCODE_WIDTH-1:0] o_opcode;
    logic                    o_busy;
    logic                    o_illegal;
    logic                    o_timeout;
    logic [COUNT_WIDTH-1:0]  o_instr_count;

    modport master (
        input  i_run, i_ir_opcode, i_memory_done,
        output o_PCout, o_IncPC, o_MARin, o_Zin,
        output o_Zlo_out, o_PCin, o_MDRin, o_Mem_Read,
        output o_Mem_enable512x32, o_MDRout, o_IRin,
        output o_Gra, o_Grb, o_Rout, o_BAout, o_Yin,
        output o_Cout, o_HIout, o_LOout, o_HIin, o_LOin, o_Rin,
        output o_opcode, o_busy, o_illegal, o_timeout,
        output o_instr_count
    );

    modport slave (
        output i_run, i_ir_opcode, i_memory_done,
        input  o_PCout, o_IncPC, o_MARin, o_Zin,
        input  o_Zlo_out, o_PCin, o_MDRin, o_Mem_Read,
        input  o_Mem_enable512x32, o_MDRout, o_IRin,
        input  o_Gra, o_Grb, o_Rout, o_BAout, o_Yin,
        input  o_Cout, o_HIout, o_LOout, o_HIin, o_LOin, o_Rin,
        input  o_opcode, o_busy, o_illegal, o_timeout,
        input  o_instr_count
    );
endinterface

// File: rtl/hilo_control_sequencer.sv
// Hardwired T-state sequencer for mvhl / mfhi / mflo.
// Moore decode of state plus t1_first; sticky illegal/timeout traps.
module hilo_control_sequencer #(
    parameter int                    OPCODE_WIDTH = 5,
    parameter logic [OPCODE_WIDTH-1:0] OP_MVHL    = 5'b00001,
    parameter logic [OPCODE_WIDTH-1:0] OP_MFHI    = 5'b00011,
    parameter logic [OPCODE_WIDTH-1:0] OP_MFLO    = 5'b01011,
    parameter logic [OPCODE_WIDTH-1:0] ALU_ADD    = 5'b00011,
    parameter int                    MEM_WAIT_MAX = 15,
    parameter int                    COUNT_WIDTH  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_clear,
    hilo_control_sequencer_if.master  bus
);
    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_t1_first, w_t1_first_nxt;
    logic [WAIT_W-1:0]      r_wait_cnt, w_wait_cnt_nxt;
    logic                   r_illegal, w_illegal_nxt;
    logic                   r_timeout, w_timeout_nxt;
    logic [COUNT_WIDTH-1:0] r_instr_count, w_instr_count_nxt;
    logic                   w_end;

    // State and status registers; clear drops everything at once
    always_ff @(posedge i_clk or posedge i_clear) begin
        if (i_clear) begin
            r_state       <= S_IDLE;
            r_t1_first    <= 1'b0;
            r_wait_cnt    <= '0;
            r_illegal     <= 1'b0;
            r_timeout     <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_t1_first    <= w_t1_first_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_illegal     <= w_illegal_nxt;
            r_timeout     <= w_timeout_nxt;
            r_instr_count <= w_instr_count_nxt;
        end
    end

    // Next-state logic and per-state strobe decode
    always_comb begin
        w_state_nxt       = r_state;
        w_t1_first_nxt    = r_t1_first;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_illegal_nxt     = r_illegal;
        w_timeout_nxt     = r_timeout;
        w_instr_count_nxt = r_instr_count;
        w_end             = 1'b0;

        bus.o_PCout            = 1'b0;
        bus.o_IncPC            = 1'b0;
        bus.o_MARin            = 1'b0;
        bus.o_Zin              = 1'b0;
        bus.o_Zlo_out          = 1'b0;
        bus.o_PCin             = 1'b0;
        bus.o_MDRin            = 1'b0;
        bus.o_Mem_Read         = 1'b0;
        bus.o_Mem_enable512x32 = 1'b0;
        bus.o_MDRout           = 1'b0;
        bus.o_IRin             = 1'b0;
        bus.o_Gra              = 1'b0;
        bus.o_Grb              = 1'b0;
        bus.o_Rout             = 1'b0;
        bus.o_BAout            = 1'b0;
        bus.o_Yin              = 1'b0;
        bus.o_Cout             = 1'b0;
        bus.o_HIout            = 1'b0;
        bus.o_LOout            = 1'b0;
        bus.o_HIin             = 1'b0;
        bus.o_LOin             = 1'b0;
        bus.o_Rin              = 1'b0;
        bus.o_opcode           = '0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.i_run) w_state_nxt = S_T0;
            end
            S_T0: begin
                bus.o_PCout    = 1'b1;
                bus.o_IncPC    = 1'b1;
                bus.o_MARin    = 1'b1;
                bus.o_Zin      = 1'b1;
                w_wait_cnt_nxt = '0;
                w_t1_first_nxt = 1'b1;
                w_state_nxt    = S_T1;
            end
            S_T1: begin
                bus.o_MDRin            = 1'b1;
                bus.o_Mem_Read         = 1'b1;
                bus.o_Mem_enable512x32 = 1'b1;
                // PC latches only on the first T1 cycle of a stretched fetch
                bus.o_Zlo_out          = r_t1_first;
                bus.o_PCin             = r_t1_first;
                w_t1_first_nxt         = 1'b0;
                if (bus.i_memory_done) begin
                    w_state_nxt = S_T2;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_HALT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            S_T2: begin
                bus.o_MDRout = 1'b1;
                bus.o_IRin   = 1'b1;
                w_state_nxt  = S_T3;
            end
            S_T3: begin
                if (bus.i_ir_opcode == OP_MFHI) begin
                    bus.o_Gra   = 1'b1;
                    bus.o_HIout = 1'b1;
                    bus.o_Rin   = 1'b1;
                    w_end       = 1'b1;
                end else if (bus.i_ir_opcode == OP_MFLO) begin
                    bus.o_Gra   = 1'b1;
                    bus.o_LOout = 1'b1;
                    bus.o_Rin   = 1'b1;
                    w_end       = 1'b1;
                end else if (bus.i_ir_opcode == OP_MVHL) begin
                    bus.o_Grb   = 1'b1;
                    bus.o_Rout  = 1'b1;
                    bus.o_BAout = 1'b1;
                    bus.o_Yin   = 1'b1;
                    w_state_nxt = S_T4;
                end else begin
                    w_illegal_nxt = 1'b1;
                    w_state_nxt   = S_HALT;
                end
            end
            S_T4: begin
                bus.o_Cout   = 1'b1;
                bus.o_Zin    = 1'b1;
                bus.o_opcode = ALU_ADD;
                w_state_nxt  = S_T5;
            end
            S_T5: begin
                bus.o_Zlo_out = 1'b1;
                bus.o_HIin    = 1'b1;
                bus.o_LOin    = 1'b1;
                w_end         = 1'b1;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Retire: count and either chain the next fetch or idle
        if (w_end) begin
            w_instr_count_nxt = r_instr_count + 1'b1;
            w_state_nxt       = bus.i_run ? S_T0 : S_IDLE;
        end
    end

    assign bus.o_busy        = (r_state != S_IDLE) && (r_state != S_HALT);
    assign bus.o_illegal     = r_illegal;
    assign bus.o_timeout     = r_timeout;
    assign bus.o_instr_count = r_instr_count;
endmodule

// File: tb/tb_hilo_control_sequencer.sv
// Bench for hilo_control_sequencer: per-instruction micro-step model
// expanded into per-cycle expectations, plus hand-computed pins.
module tb_hilo_control_sequencer;
    localparam logic [4:0] OP_MVHL = 5'b00001;
    localparam logic [4:0] OP_MFHI = 5'b00011;
    localparam logic [4:0] OP_MFLO = 5'b01011;
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam int         WMAX    = 15;

    localparam logic [21:0] M_PCOUT  = 22'd1 << 0;
    localparam logic [21:0] M_INCPC  = 22'd1 << 1;
    localparam logic [21:0] M_MARIN  = 22'd1 << 2;
    localparam logic [21:0] M_ZIN    = 22'd1 << 3;
    localparam logic [21:0] M_ZLO    = 22'd1 << 4;
    localparam logic [21:0] M_PCIN   = 22'd1 << 5;
    localparam logic [21:0] M_MDRIN  = 22'd1 << 6;
    localparam logic [21:0] M_MEMRD  = 22'd1 << 7;
    localparam logic [21:0] M_MEMEN  = 22'd1 << 8;
    localparam logic [21:0] M_MDROUT = 22'd1 << 9;
    localparam logic [21:0] M_IRIN   = 22'd1 << 10;
    localparam logic [21:0] M_GRA    = 22'd1 << 11;
    localparam logic [21:0] M_GRB    = 22'd1 << 12;
    localparam logic [21:0] M_ROUT   = 22'd1 << 13;
    localparam logic [21:0] M_BAOUT  = 22'd1 << 14;
    localparam logic [21:0] M_YIN    = 22'd1 << 15;
    localparam logic [21:0] M_COUT   = 22'd1 << 16;
    localparam logic [21:0] M_HIOUT  = 22'd1 << 17;
    localparam logic [21:0] M_LOOUT  = 22'd1 << 18;
    localparam logic [21:0] M_HIIN   = 22'd1 << 19;
    localparam logic [21:0] M_LOIN   = 22'd1 << 20;
    localparam logic [21:0] M_RIN    = 22'd1 << 21;

    typedef struct packed {
        logic [21:0] s;
        logic [4:0]  op;
        logic        busy;
        logic        ill;
        logic        to;
        logic [15:0] cnt;
        logic        run;
        logic        md;
        logic [4:0]  ir;
    } ent_t;

    logic clk = 1'b0;
    logic clear = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ent_t q[$];
    logic [15:0] m_cnt;
    logic        m_ill;
    logic        m_to;
    int n_busy, n_pcin, n_mem, n_rin, hiin_at, alu_at;

    hilo_control_sequencer_if b ();

    hilo_control_sequencer dut (
        .i_clk   (clk),
        .i_clear (clear),
        .bus     (b)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] pack();
        return {b.o_Rin, b.o_LOin, b.o_HIin, b.o_LOout,
                b.o_HIout, b.o_Cout, b.o_Yin, b.o_BAout,
                b.o_Rout, b.o_Grb, b.o_Gra, b.o_IRin,
                b.o_MDRout, b.o_Mem_enable512x32,
                b.o_Mem_Read, b.o_MDRin, b.o_PCin,
                b.o_Zlo_out, b.o_Zin, b.o_MARin,
                b.o_IncPC, b.o_PCout};
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic void push(input logic [21:0] s,
                                 input logic [4:0] op,
                                 input logic busy,
                                 input logic run,
                                 input logic md,
                                 input logic [4:0] ir);
        ent_t e;
        e.s    = s;
        e.op   = op;
        e.busy = busy;
        e.ill  = m_ill;
        e.to   = m_to;
        e.cnt  = m_cnt;
        e.run  = run;
        e.md   = md;
        e.ir   = ir;
        q.push_back(e);
    endfunction

    // Idle or halted cycles: nothing driven, flags/count as modelled
    task automatic add_quiet(input int n, input logic run);
        for (int i = 0; i < n; i++)
            push(22'd0, 5'd0, 1'b0, run, 1'b0, 5'd0);
    endtask

    // One instruction: fetch, memory wait of 'delay' cycles, execute
    task automatic add_instr(input logic [4:0] ir, input int delay,
                             input logic run_mid,
                             input logic run_end);
        int n_t1;
        push(M_PCOUT | M_INCPC | M_MARIN | M_ZIN,
             5'd0, 1'b1, 1'b1, 1'b0, ir);
        n_t1 = (delay < WMAX) ? delay + 1 : WMAX;
        for (int i = 0; i < n_t1; i++)
            push(M_MDRIN | M_MEMRD | M_MEMEN |
                 ((i == 0) ? (M_ZLO | M_PCIN) : 22'd0),
                 5'd0, 1'b1, 1'b1, (i == delay), ir);
        if (delay >= WMAX) begin
            m_to = 1'b1;
            return;
        end
        push(M_MDROUT | M_IRIN, 5'd0, 1'b1, run_mid, 1'b0, ir);
        if (ir == OP_MFHI) begin
            push(M_GRA | M_HIOUT | M_RIN, 5'd0, 1'b1,
                 run_end, 1'b0, ir);
            m_cnt = m_cnt + 16'd1;
        end else if (ir == OP_MFLO) begin
            push(M_GRA | M_LOOUT | M_RIN, 5'd0, 1'b1,
                 run_end, 1'b0, ir);
            m_cnt = m_cnt + 16'd1;
        end else if (ir == OP_MVHL) begin
            push(M_GRB | M_ROUT | M_BAOUT | M_YIN, 5'd0, 1'b1,
                 run_mid, 1'b0, ir);
            push(M_COUT | M_ZIN, ALU_ADD, 1'b1,
                 run_mid, 1'b0, ir);
            push(M_ZLO | M_HIIN | M_LOIN, 5'd0, 1'b1,
                 run_end, 1'b0, ir);
            m_cnt = m_cnt + 16'd1;
        end else begin
            push(22'd0, 5'd0, 1'b1, run_mid, 1'b0, ir);
            m_ill = 1'b1;
        end
    endtask

    // Walk the expectation queue one clock at a time
    task automatic run_q(input string tag);
        n_busy  = 0;
        n_pcin  = 0;
        n_mem   = 0;
        n_rin   = 0;
        hiin_at = 0;
        alu_at  = 0;
        foreach (q[k]) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s c%0d strobes", tag, k),
                32'(pack()), 32'(q[k].s));
            chk($sformatf("%s c%0d opcode", tag, k),
                32'(b.o_opcode), 32'(q[k].op));
            chk($sformatf("%s c%0d busy", tag, k),
                32'(b.o_busy), 32'(q[k].busy));
            chk($sformatf("%s c%0d flags", tag, k),
                32'({b.o_illegal, b.o_timeout}),
                32'({q[k].ill, q[k].to}));
            chk($sformatf("%s c%0d count", tag, k),
                32'(b.o_instr_count), 32'(q[k].cnt));
            if (b.o_busy) begin
                n_busy++;
                if (b.o_HIin && hiin_at == 0) hiin_at = n_busy;
                if (b.o_opcode == ALU_ADD && alu_at == 0)
                    alu_at = n_busy;
            end
            n_pcin += int'(b.o_PCin);
            n_mem  += int'(b.o_Mem_Read);
            n_rin  += int'(b.o_Rin);
            b.i_run         = q[k].run;
            b.i_memory_done = q[k].md;
            b.i_ir_opcode   = q[k].ir;
        end
        q.delete();
    endtask

    task automatic do_reset(input string tag);
        b.i_run         = 1'b0;
        b.i_memory_done = 1'b0;
        b.i_ir_opcode   = 5'd0;
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk({tag, " rst strobes"}, 32'(pack()), 32'd0);
        chk({tag, " rst status"},
            32'({b.o_busy, b.o_illegal, b.o_timeout,
                 b.o_instr_count}), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        m_cnt = 16'd0;
        m_ill = 1'b0;
        m_to  = 1'b0;
        q.delete();
    endtask

    initial begin
        b.i_run         = 1'b0;
        b.i_memory_done = 1'b0;
        b.i_ir_opcode   = 5'd0;

        // mvhl alone, memory ready immediately
        do_reset("s1");
        add_quiet(1, 1'b1);
        add_instr(OP_MVHL, 0, 1'b1, 1'b0);
        add_quiet(2, 1'b0);
        run_q("s1");
        chk("s1 latency", 32'(n_busy), 32'd6);
        chk("s1 hiin_cycle", 32'(hiin_at), 32'd6);
        chk("s1 alu_cycle", 32'(alu_at), 32'd5);
        chk("s1 count", 32'(b.o_instr_count), 32'd1);

        // mvhl, mfhi, mflo back to back
        do_reset("s2");
        add_quiet(1, 1'b1);
        add_instr(OP_MVHL, 0, 1'b1, 1'b1);
        add_instr(OP_MFHI, 0, 1'b1, 1'b1);
        add_instr(OP_MFLO, 0, 1'b1, 1'b0);
        add_quiet(2, 1'b0);
        run_q("s2");
        chk("s2 busy_cycles", 32'(n_busy), 32'd14);
        chk("s2 pcin_pulses", 32'(n_pcin), 32'd3);
        chk("s2 count", 32'(b.o_instr_count), 32'd3);

        // mfhi with 3-cycle memory stall, run dropped in T2
        do_reset("s3");
        add_quiet(1, 1'b1);
        add_instr(OP_MFHI, 3, 1'b0, 1'b0);
        add_quiet(3, 1'b0);
        run_q("s3");
        chk("s3 latency", 32'(n_busy), 32'd7);
        chk("s3 memrd_cycles", 32'(n_mem), 32'd4);
        chk("s3 pcin_pulses", 32'(n_pcin), 32'd1);
        chk("s3 count", 32'(b.o_instr_count), 32'd1);

        // memory_done on the last allowed T1 cycle still proceeds
        do_reset("s4");
        add_quiet(1, 1'b1);
        add_instr(OP_MFHI, WMAX - 1, 1'b1, 1'b1);
        run_q("s4a");
        chk("s4a memrd_cycles", 32'(n_mem), 32'd15);
        chk("s4a timeout", 32'(b.o_timeout), 32'd0);
        // then a fetch that never completes
        add_instr(OP_MFHI, 1000, 1'b1, 1'b1);
        add_quiet(3, 1'b1);
        run_q("s4b");
        chk("s4b memrd_cycles", 32'(n_mem), 32'd15);
        chk("s4b timeout", 32'(b.o_timeout), 32'd1);
        chk("s4b busy", 32'(b.o_busy), 32'd0);
        chk("s4b count", 32'(b.o_instr_count), 32'd1);
        do_reset("s4c");
        chk("s4c timeout_cleared", 32'(b.o_timeout), 32'd0);

        // undecodable opcode traps
        do_reset("s5");
        add_quiet(1, 1'b1);
        add_instr(5'b11111, 0, 1'b1, 1'b1);
        add_quiet(3, 1'b1);
        run_q("s5");
        chk("s5 illegal", 32'(b.o_illegal), 32'd1);
        chk("s5 rin_pulses", 32'(n_rin), 32'd0);
        chk("s5 count", 32'(b.o_instr_count), 32'd0);

        // asynchronous clear in T4 of mvhl
        do_reset("s6");
        b.i_ir_opcode   = OP_MVHL;
        b.i_memory_done = 1'b1;
        b.i_run         = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("s6 t4_cout", 32'(b.o_Cout), 32'd1);
        chk("s6 t4_opcode", 32'(b.o_opcode), 32'(ALU_ADD));
        #2;
        clear = 1'b1;
        #1;
        chk("s6 async_strobes", 32'(pack()), 32'd0);
        chk("s6 async_opcode", 32'(b.o_opcode), 32'd0);
        chk("s6 async_busy", 32'(b.o_busy), 32'd0);
        @(posedge clk);
        #1;
        chk("s6 no_hilo_in",
            32'({b.o_HIin, b.o_LOin}), 32'd0);
        @(negedge clk);
        b.i_run = 1'b0;
        clear   = 1'b0;
        @(posedge clk);
        #1;
        chk("s6 idle_busy", 32'(b.o_busy), 32'd0);
        chk("s6 count", 32'(b.o_instr_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
